// File: rtl/ahb_slave_port_ctrl_if.sv
// ahb_slave_port_ctrl_if: AHB encodings and the bus bundle between masters, arbiter and one slave port
package AHB_package;
   typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_type;
   localparam logic [1:0] HT_IDLE = 2'd0, HT_BUSY = 2'd1, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3;
endpackage

interface ahb_slave_port_ctrl_if #(parameter int MASTER_NUM = 4);
   import AHB_package::*;
   logic [MASTER_NUM-1:0] hgrant;
   logic [1:0]            m_htrans [MASTER_NUM];
   hburst_type            m_hburst [MASTER_NUM];
   logic                  s_hreadyout;
   logic                  s_hresp;
   logic                  s_hsel;
   logic [MASTER_NUM-1:0] addr_sel;
   logic [MASTER_NUM-1:0] data_sel;
   logic [MASTER_NUM-1:0] m_hready;
   logic [MASTER_NUM-1:0] m_hresp;
   logic                  hold_grant;
   logic [3:0]            beat_cnt;
   logic                  proto_err;
   modport slave (
      input  hgrant, m_htrans, m_hburst, s_hreadyout, s_hresp,
      output s_hsel, addr_sel, data_sel, m_hready, m_hresp, hold_grant, beat_cnt, proto_err
   );
   modport master (
      output hgrant, m_htrans, m_hburst, s_hreadyout, s_hresp,
      input  s_hsel, addr_sel, data_sel, m_hready, m_hresp, hold_grant, beat_cnt, proto_err
   );
endinterface

// File: rtl/ahb_slave_port_ctrl.sv
// ahb_slave_port_ctrl: per-slave mux steering, response routing and burst tracking for a shared AHB slave
module ahb_slave_port_ctrl
   import AHB_package::*;
#(
   parameter int MASTER_NUM = 4
) (
   input logic hclk,
   input logic hreset,
   ahb_slave_port_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BURST, UNDEF, ERROR} state_t;
   state_t                state, state_nx, start_state;
   logic [3:0]            beat_q, beat_nx, limit_q, limit_nx, start_beat, start_limit;
   logic [MASTER_NUM-1:0] data_sel_q, prev_grant;
   logic                  proto_q, proto_nx;
   logic [1:0]            own_trans;
   hburst_type            own_burst;
   logic                  acc, acc_ns, acc_seq, done, err;
   always_comb begin
      own_trans = HT_IDLE;
      own_burst = SINGLE;
      for (int i = 0; i < MASTER_NUM; i++)
         if (bus.hgrant[i]) begin
            own_trans = bus.m_htrans[i];
            own_burst = bus.m_hburst[i];
         end
   end
   assign bus.addr_sel   = bus.hgrant;
   assign bus.s_hsel     = |bus.hgrant && own_trans[1];
   assign bus.data_sel   = data_sel_q;
   assign bus.beat_cnt   = beat_q;
   assign bus.proto_err  = proto_q;
   assign bus.hold_grant = state == BURST || state == UNDEF;
   assign bus.m_hready   = hreset ? '1 : ~data_sel_q | {MASTER_NUM{bus.s_hreadyout}};
   assign bus.m_hresp    = hreset ? '0 : data_sel_q & {MASTER_NUM{bus.s_hresp}};
   assign acc     = bus.s_hsel && bus.s_hreadyout;
   assign acc_ns  = acc && own_trans == HT_NONSEQ;
   assign acc_seq = acc && own_trans == HT_SEQ;
   assign done    = beat_q == limit_q;
   assign err     = bus.s_hresp && !bus.s_hreadyout && |data_sel_q;
   // Evaluation of a possible burst start, shared by every path that may see a new NONSEQ
   assign start_state = !acc_ns || own_burst == SINGLE ? IDLE : own_burst == INCR ? UNDEF : BURST;
   assign start_beat  = acc_ns && own_burst != SINGLE ? 4'd0 : beat_q;
   assign start_limit = !acc_ns || own_burst == SINGLE || own_burst == INCR ? limit_q :
                        own_burst[2:1] == 2'd1 ? 4'd3 : own_burst[2:1] == 2'd2 ? 4'd7 : 4'd15;
   always_comb begin
      state_nx = state;
      beat_nx  = beat_q;
      limit_nx = limit_q;
      if (err)
         state_nx = ERROR;
      else if (bus.s_hreadyout)
         case (state)
            IDLE: begin
               state_nx = start_state;
               beat_nx  = start_beat;
               limit_nx = start_limit;
            end
            BURST:
               if (done || acc_ns) begin
                  state_nx = start_state;
                  beat_nx  = start_beat;
                  limit_nx = start_limit;
               end else if (acc_seq)
                  beat_nx = beat_q + 4'd1;
            UNDEF:
               if (own_trans == HT_IDLE || own_trans == HT_NONSEQ) begin
                  state_nx = start_state;
                  beat_nx  = start_beat;
                  limit_nx = start_limit;
               end else if (acc_seq && beat_q != 4'd15)
                  beat_nx = beat_q + 4'd1;
            ERROR: begin
               state_nx = IDLE;
               beat_nx  = 4'd0;
            end
         endcase
   end
   assign proto_nx = (state == IDLE && bus.s_hsel && own_trans == HT_SEQ) ||
                     (state == BURST && !done && acc_ns) ||
                     (bus.hold_grant && bus.hgrant != prev_grant);
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state      <= IDLE;
         beat_q     <= 4'd0;
         limit_q    <= 4'd0;
         data_sel_q <= '0;
         prev_grant <= '0;
         proto_q    <= 1'b0;
      end else begin
         state      <= state_nx;
         beat_q     <= beat_nx;
         limit_q    <= limit_nx;
         data_sel_q <= bus.s_hreadyout ? (acc ? bus.hgrant : '0) : data_sel_q;
         prev_grant <= bus.hgrant;
         proto_q    <= proto_nx;
      end
   end
endmodule

// File: doc/ahb_slave_port_ctrl.md
AHB_SLAVE_PORT_CTRL -- requirements
Module: ahb_slave_port_ctrl

Interface
REQ-001 SHALL provide parameter MASTER_NUM, default 4, meaning number of masters sharing this slave port (2..16).
REQ-002 SHALL provide ports:
- hclk  in  1  rising-edge clock
- hreset  in  1  reset
- hgrant  in  MASTER_NUM  one-hot address-phase grant from the per-slave arbiter
- m_htrans  in  MASTER_NUM x 2  per-master HTRANS
- m_hburst  in  MASTER_NUM x hburst_type  per-master HBURST (AHB_package)
- s_hreadyout  in  1  slave HREADYOUT
- s_hresp  in  1  slave HRESP, 1 = ERROR
- s_hsel  out  1  slave select
- addr_sel  out  MASTER_NUM  one-hot address/control mux select
- data_sel  out  MASTER_NUM  one-hot write-data/response mux select
- m_hready  out  MASTER_NUM  per-master HREADY
- m_hresp  out  MASTER_NUM  per-master HRESP
- hold_grant  out  1  request to arbiter to keep current grant
- beat_cnt  out  4  accepted beats in current burst, minus 1
- proto_err  out  1  one-cycle protocol-violation pulse
REQ-003 SHALL use one clock hclk; reset hreset is synchronous and active-high.

Function
REQ-004 SHALL use encodings HTRANS IDLE=0, BUSY=1, NONSEQ=2, SEQ=3; HBURST SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
REQ-005 SHALL drive addr_sel = hgrant combinationally.
REQ-006 SHALL drive s_hsel = |hgrant AND owner htrans in {NONSEQ, SEQ}, where the owner is the master selected by hgrant.
REQ-007 SHALL treat a transfer as accepted when s_hsel=1 and s_hreadyout=1 in the same cycle.
REQ-008 SHALL register data_sel: on s_hreadyout=1, load addr_sel if a transfer is accepted, otherwise load 0; on s_hreadyout=0, hold.
REQ-009 SHALL drive m_hready[i] = s_hreadyout and m_hresp[i] = s_hresp when data_sel[i]=1; otherwise m_hready[i]=1 and m_hresp[i]=0.
REQ-010 SHALL implement FSM states IDLE, BURST, UNDEF and ERROR.
REQ-011 IDLE transitions:
- accepted NONSEQ with WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16 -> BURST, load limit 3/7/15, beat_cnt=0.
- accepted NONSEQ INCR -> UNDEF, beat_cnt=0.
- NONSEQ SINGLE stays in IDLE.
REQ-012 BURST:
- each accepted SEQ increments beat_cnt.
- the accepted SEQ that makes beat_cnt equal the limit returns the FSM to IDLE next cycle.
- owner BUSY holds the count.
REQ-013 UNDEF:
- accepted SEQ increments beat_cnt, saturating at 15.
- owner htrans IDLE or NONSEQ returns to IDLE; an accepted NONSEQ is then re-evaluated per REQ-011 in the same cycle.
REQ-014 hold_grant SHALL be 1 in BURST and UNDEF and 0 in IDLE and ERROR.
REQ-015 Error handling:
- s_hresp=1 with s_hreadyout=0 while data_sel is nonzero, in any state, -> ERROR.
- ERROR returns to IDLE on the cycle s_hreadyout=1, clearing beat_cnt.
- the burst is abandoned, not resumed.
REQ-016 SHALL pulse proto_err for one cycle on any of:
- owner SEQ with s_hsel=1 while in IDLE.
- owner NONSEQ accepted while in BURST.
- hgrant changes while hold_grant=1.
REQ-017 A proto_err cause SHALL NOT alter FSM state or beat_cnt, except that an accepted NONSEQ in BURST is re-evaluated per REQ-011.
REQ-018 SHALL keep data_sel, FSM and beat_cnt stable for the whole time s_hreadyout=0, except for the IDLE/BURST/UNDEF -> ERROR transition in REQ-015.
REQ-019 A simultaneous final BURST beat acceptance and new NONSEQ from the same owner in the next cycle SHALL be accepted without an idle cycle.

Reset
REQ-020 On hreset=1 at a rising edge, SHALL set:
- FSM = IDLE
- data_sel = 0
- beat_cnt = 0
- hold_grant = 0
- proto_err = 0
REQ-021 Reset SHALL take priority over all other events, including mid-burst and in ERROR.
REQ-022 While hreset=1, m_hready SHALL be all ones and m_hresp all zeros.

Verification
REQ-023 Bench SHALL cover:
- hgrant=0001, NONSEQ INCR4, then 3 SEQ, s_hreadyout=1 -> hold_grant 1 for 4 cycles, beat_cnt 0..3, IDLE after beat 4, data_sel=0001 lagging addr_sel by one cycle.
- INCR8 with s_hreadyout=0 for 2 cycles on beat 3 -> beat_cnt holds at 2, m_hready[0]=0 for 2 cycles, burst completes after 8 accepted beats.
- INCR16 owner=0100, error on beat 5 (hresp=1/hreadyout=0, then hresp=1/hreadyout=1) -> m_hresp[2]=1 for 2 cycles, hold_grant drops, FSM IDLE, beat_cnt=0.
- Undefined INCR from master 1 with 20 SEQs then IDLE -> beat_cnt saturates at 15, hold_grant falls the cycle after IDLE.
- hgrant switches 0001->0010 mid-INCR4 -> proto_err one-cycle pulse, FSM unchanged.
- hreset=1 during beat 2 of WRAP8 -> next cycle FSM IDLE, data_sel=0, beat_cnt=0, hold_grant=0.
